// File: rtl/sig_deb_evt_multi.sv
// N-channel button front end: two-flop synchroniser, shared sample prescaler,
// per-channel debounce window, press/release/long-hold pulses and a
// mode-selected output bit per channel.
module sig_deb_evt_multi #(
    parameter int N             = 4,
    parameter int CLKS_PER_SMPL = 16,
    parameter int SMPL_CNT      = 4,
    parameter int HOLD_TICKS    = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_sig,
    input  logic [1:0]   mode,
    input  logic         clr,
    output logic [N-1:0] o_deb,
    output logic [N-1:0] o_press,
    output logic [N-1:0] o_rel,
    output logic [N-1:0] o_hold,
    output logic [N-1:0] o_state
);

    // Prescaler width; a 1-clock sample period still needs a 1-bit counter.
    localparam int PW = (CLKS_PER_SMPL > 1) ? $clog2(CLKS_PER_SMPL) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLKS_PER_SMPL - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {
        MODE_PRESS  = 2'b00,
        MODE_REL    = 2'b01,
        MODE_FOLLOW = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [N-1:0]  sync1_q;
    logic [N-1:0]  sync2_q;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick;

    // Shared prescaler: tick on the last count of each sample period.
    always_comb begin
        tick  = (pre_q == PRE_MAX);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Prescaler and two-flop synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            pre_q   <= pre_d;
            sync1_q <= i_sig;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : gen_ch
            logic [SMPL_CNT-1:0] win_q;
            logic [SMPL_CNT-1:0] win_d;
            logic                deb_q;
            logic                deb_d;
            logic                deb_dly_q;
            logic [HW-1:0]       hcnt_q;
            logic [HW-1:0]       hcnt_d;
            logic                hdone_q;
            logic                hdone_d;
            logic                press_q;
            logic                press_d;
            logic                rel_q;
            logic                rel_d;
            logic                hold_q;
            logic                hold_d;
            logic                state_q;
            logic                state_d;

            // Next state: sample window, debounced level, hold counter, event pulses, output bit.
            always_comb begin
                win_d   = win_q;
                deb_d   = deb_q;
                hcnt_d  = hcnt_q;
                hdone_d = hdone_q;
                hold_d  = 1'b0;
                state_d = state_q;

                if (tick) begin
                    win_d = {win_q[SMPL_CNT-2:0], sync2_q[gi]};
                    if (&win_d) begin
                        deb_d = 1'b1;
                    end else if (~|win_d) begin
                        deb_d = 1'b0;
                    end
                end

                // Pulses trail the debounced edge by one cycle.
                press_d = deb_q & ~deb_dly_q;
                rel_d   = ~deb_q & deb_dly_q;

                // hdone blocks a second hold pulse until the button is released.
                if (!deb_q) begin
                    hcnt_d  = '0;
                    hdone_d = 1'b0;
                end else begin
                    if (tick && (hcnt_q != HOLD_MAX)) begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                    if ((hcnt_q == HOLD_MAX) && !hdone_q) begin
                        hold_d  = 1'b1;
                        hdone_d = 1'b1;
                    end
                end

                // Output bit changes on the same edge its triggering pulse asserts.
                case (mode_e'(mode))
                    MODE_PRESS:  if (press_d) state_d = ~state_q;
                    MODE_REL:    if (rel_d)   state_d = ~state_q;
                    MODE_FOLLOW: state_d = deb_q;
                    MODE_HOLD:   if (hold_d)  state_d = ~state_q;
                    default:     state_d = state_q;
                endcase

                if (clr) begin
                    state_d = 1'b0;
                end
            end

            // Per-channel state registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    win_q     <= '0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                    hcnt_q    <= '0;
                    hdone_q   <= 1'b0;
                    press_q   <= 1'b0;
                    rel_q     <= 1'b0;
                    hold_q    <= 1'b0;
                    state_q   <= 1'b0;
                end else begin
                    win_q     <= win_d;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_q;
                    hcnt_q    <= hcnt_d;
                    hdone_q   <= hdone_d;
                    press_q   <= press_d;
                    rel_q     <= rel_d;
                    hold_q    <= hold_d;
                    state_q   <= state_d;
                end
            end

            assign o_deb[gi]   = deb_q;
            assign o_press[gi] = press_q;
            assign o_rel[gi]   = rel_q;
            assign o_hold[gi]  = hold_q;
            assign o_state[gi] = state_q;
        end
    endgenerate

endmodule

// File: tb/tb_sig_deb_evt_multi.sv
// Scoreboard bench for sig_deb_evt_multi: scenarios push expected pulse
// events; a negedge monitor records what the design emits; each scenario
// then pops and compares the two queues.
module tb_sig_deb_evt_multi;

    localparam int N    = 2;
    localparam int CPS  = 4;
    localparam int SC   = 3;
    localparam int HT   = 5;

    typedef struct {
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] hold;
        logic [1:0] state;
        int         cyc;
    } ev_t;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] i_sig;
    logic [1:0]   mode;
    logic         clr;
    logic [N-1:0] o_deb;
    logic [N-1:0] o_press;
    logic [N-1:0] o_rel;
    logic [N-1:0] o_hold;
    logic [N-1:0] o_state;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    sig_deb_evt_multi #(
        .N(N), .CLKS_PER_SMPL(CPS), .SMPL_CNT(SC), .HOLD_TICKS(HT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_sig(i_sig), .mode(mode), .clr(clr),
        .o_deb(o_deb), .o_press(o_press), .o_rel(o_rel), .o_hold(o_hold),
        .o_state(o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one record per cycle in which any pulse is high.
    always @(negedge clk) begin
        ev_t ev;
        if (rst_n === 1'b1 && (o_press | o_rel | o_hold) !== 2'b00) begin
            ev.press = o_press;
            ev.rel   = o_rel;
            ev.hold  = o_hold;
            ev.state = o_state;
            ev.cyc   = cyc;
            obs_q.push_back(ev);
            $display("[TB] cyc=%0d press=%b rel=%b hold=%b state=%b deb=%b",
                     cyc, o_press, o_rel, o_hold, o_state, o_deb);
        end
    end

    task automatic expect_ev(input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] h, input logic [1:0] s);
        ev_t e;
        e.press = p; e.rel = r; e.hold = h; e.state = s; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic test_reset();
        ev_t e, o;
        bit  found;
        int  lat;
        rst_n = 1'b0; i_sig = 2'b11; mode = 2'b00; clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({o_deb, o_press, o_rel, o_hold, o_state} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got deb/press/rel/hold/state=%b/%b/%b/%b/%b required all 0",
                     o_deb, o_press, o_rel, o_hold, o_state);
        end
        expect_ev(2'b11, 2'b00, 2'b00, 2'b11);
        @(posedge clk); #1 rst_n = 1'b1;
        found = 0; lat = 0;
        for (int i = 1; i <= 16 && !found; i++) begin
            @(negedge clk);
            if (o_deb === 2'b11) begin found = 1; lat = i; end
        end
        n_tests++;
        if (!found || lat > 2 + CPS * SC) begin
            n_fail++;
            $display("FAIL reset_latency: got o_deb=%b after %0d cycles required 11 within %0d",
                     o_deb, lat, 2 + CPS * SC);
        end
        i_sig = 2'b00;
        expect_ev(2'b00, 2'b11, 2'b00, 2'b11);
        repeat (30) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_ev: missing event, required p/r/h/s=%b/%b/%b/%b",
                         e.press, e.rel, e.hold, e.state);
            end else begin
                o = obs_q.pop_front();
                if ({o.press, o.rel, o.hold, o.state} !== {e.press, e.rel, e.hold, e.state}) begin
                    n_fail++;
                    $display("FAIL reset_ev: got p/r/h/s=%b/%b/%b/%b required %b/%b/%b/%b",
                             o.press, o.rel, o.hold, o.state, e.press, e.rel, e.hold, e.state);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_extra: got %0d unexpected events required 0", obs_q.size());
            obs_q.delete();
        end
        pulse_clr();
        @(negedge clk);
        n_tests++;
        if (o_state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_clr: got o_state=%b required 00", o_state);
        end
    endtask

    task automatic test_bounce();
        int deb_hits;
        deb_hits = 0;
        mode = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            i_sig[0] = ~i_sig[0];
            repeat (3) begin
                @(negedge clk);
                if (o_deb[0] !== 1'b0) deb_hits++;
            end
        end
        i_sig[0] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_deb[0] !== 1'b0) deb_hits++;
        end
        n_tests++;
        if (deb_hits != 0) begin
            n_fail++;
            $display("FAIL bounce_deb: got o_deb[0]=1 in %0d cycles required 0", deb_hits);
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got %0d events required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_mode_press();
        ev_t e, o;
        pulse_clr();
        mode = 2'b00;
        expect_ev(2'b01, 2'b00, 2'b00, 2'b01);
        expect_ev(2'b00, 2'b00, 2'b01, 2'b01);
        expect_ev(2'b00, 2'b01, 2'b00, 2'b01);
        @(negedge clk); i_sig[0] = 1'b1;
        repeat (40) @(negedge clk);
        i_sig[0] = 1'b0;
        repeat (30) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL mode00_ev: missing event, required p/r/h/s=%b/%b/%b/%b",
                         e.press, e.rel, e.hold, e.state);
            end else begin
                o = obs_q.pop_front();
                if ({o.press, o.rel, o.hold, o.state} !== {e.press, e.rel, e.hold, e.state}) begin
                    n_fail++;
                    $display("FAIL mode00_ev: got p/r/h/s=%b/%b/%b/%b required %b/%b/%b/%b",
                             o.press, o.rel, o.hold, o.state, e.press, e.rel, e.hold, e.state);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL mode00_extra: got %0d unexpected events required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_mode_rel_hold();
        ev_t e, o;
        int  pc, hc;
        pc = -1; hc = -1;
        pulse_clr();
        mode = 2'b01;
        expect_ev(2'b10, 2'b00, 2'b00, 2'b00);
        expect_ev(2'b00, 2'b10, 2'b00, 2'b10);
        @(negedge clk); i_sig[1] = 1'b1;
        repeat (14) @(negedge clk);
        i_sig[1] = 1'b0;
        repeat (30) @(negedge clk);
        mode = 2'b11;
        expect_ev(2'b10, 2'b00, 2'b00, 2'b10);
        expect_ev(2'b00, 2'b00, 2'b10, 2'b00);
        expect_ev(2'b00, 2'b10, 2'b00, 2'b00);
        @(negedge clk); i_sig[1] = 1'b1;
        repeat (40) @(negedge clk);
        i_sig[1] = 1'b0;
        repeat (30) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL mode01_11_ev: missing event, required p/r/h/s=%b/%b/%b/%b",
                         e.press, e.rel, e.hold, e.state);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== 2'b00) pc = o.cyc;
                if (o.hold !== 2'b00) hc = o.cyc;
                if ({o.press, o.rel, o.hold, o.state} !== {e.press, e.rel, e.hold, e.state}) begin
                    n_fail++;
                    $display("FAIL mode01_11_ev: got p/r/h/s=%b/%b/%b/%b required %b/%b/%b/%b",
                             o.press, o.rel, o.hold, o.state, e.press, e.rel, e.hold, e.state);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL mode01_11_extra: got %0d unexpected events required 0", obs_q.size());
            obs_q.delete();
        end
        n_tests++;
        if (hc - pc != HT * CPS) begin
            n_fail++;
            $display("FAIL hold_delay: got %0d cycles press->hold required %0d", hc - pc, HT * CPS);
        end
    endtask

    task automatic test_clr_press();
        ev_t e, o;
        bit  found;
        pulse_clr();
        mode = 2'b00;
        expect_ev(2'b01, 2'b00, 2'b00, 2'b00);
        expect_ev(2'b00, 2'b01, 2'b00, 2'b00);
        @(negedge clk); i_sig[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (o_deb[0] === 1'b1) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL clr_deb_timeout: got o_deb=%b required bit0 set within 20 cycles", o_deb);
        end
        clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({o_press[0], o_state[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL clr_priority: got press0/state0=%b/%b required 1/0", o_press[0], o_state[0]);
        end
        clr = 1'b0;
        i_sig[0] = 1'b0;
        repeat (30) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL clr_ev: missing event, required p/r/h/s=%b/%b/%b/%b",
                         e.press, e.rel, e.hold, e.state);
            end else begin
                o = obs_q.pop_front();
                if ({o.press, o.rel, o.hold, o.state} !== {e.press, e.rel, e.hold, e.state}) begin
                    n_fail++;
                    $display("FAIL clr_ev: got p/r/h/s=%b/%b/%b/%b required %b/%b/%b/%b",
                             o.press, o.rel, o.hold, o.state, e.press, e.rel, e.hold, e.state);
                end
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL clr_extra: got %0d unexpected events required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        bit  found;
        pulse_clr();
        mode = 2'b10;
        repeat (2) @(negedge clk);
        expect_ev(2'b11, 2'b00, 2'b00, 2'b11);
        i_sig = 2'b11;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (o_deb !== 2'b00) found = 1;
        end
        n_tests++;
        if (!found || o_deb !== 2'b11 || o_state !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_deb: got o_deb=%b o_state=%b required 11/00", o_deb, o_state);
        end
        @(negedge clk);
        n_tests++;
        if (o_press !== 2'b11 || o_state !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_press: got o_press=%b o_state=%b required 11/11", o_press, o_state);
        end
        repeat (6) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_ev: missing event, required p/r/h/s=%b/%b/%b/%b",
                         e.press, e.rel, e.hold, e.state);
            end else begin
                o = obs_q.pop_front();
                if ({o.press, o.rel, o.hold, o.state} !== {e.press, e.rel, e.hold, e.state}) begin
                    n_fail++;
                    $display("FAIL b2b_ev: got p/r/h/s=%b/%b/%b/%b required %b/%b/%b/%b",
                             o.press, o.rel, o.hold, o.state, e.press, e.rel, e.hold, e.state);
                end
            end
        end
        // Reset in the middle of the hold count.
        @(posedge clk); #1 rst_n = 1'b0; i_sig = 2'b00;
        #1;
        n_tests++;
        if ({o_deb, o_press, o_rel, o_hold, o_state} !== 10'd0) begin
            n_fail++;
            $display("FAIL b2b_async_rst: got deb/press/rel/hold/state=%b/%b/%b/%b/%b required all 0",
                     o_deb, o_press, o_rel, o_hold, o_state);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_tests++;
        if (obs_q.size() != 0 || o_deb !== 2'b00 || o_state !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_after_rst: got %0d events o_deb=%b o_state=%b required 0/00/00",
                     obs_q.size(), o_deb, o_state);
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_mode_press();
        test_mode_rel_hold();
        test_clr_press();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
